// File: rtl/apb_package.sv
// Shared APB widths, the arbiter FSM state type and the captured request record.
// The optional access timeout is enabled by defining APB_ARB_TIMEOUT_EN.
package apb_package;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  // Write data and strobes are already zeroed for reads when this is built.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } apb_req_t;

endpackage

// File: rtl/apb_interface.sv
// APB master/slave signal bundle with protocol assertions that watch whichever
// master drives it.
interface apb_interface
  import apb_package::*;
(
  input logic PCLK,
  input logic PRESETn
);

  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

  a_enable_needs_sel: assert property (@(posedge PCLK) disable iff (!PRESETn)
    PENABLE |-> PSELx);

  a_setup_one_cycle: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (PSELx && !PENABLE) |=> (PSELx && PENABLE));

  // A dropped PSELx is allowed mid-wait so an aborted access does not trip this.
  a_access_stable: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (PSELx && PENABLE && !PREADY) |=>
      (!PSELx || (PENABLE && $stable(PADDR) && $stable(PWRITE) &&
                  $stable(PWDATA) && $stable(PSTRB))));

  a_idle_quiet: assert property (@(posedge PCLK) disable iff (!PRESETn)
    !PSELx |-> (!PENABLE && !PWRITE && PADDR == '0 && PWDATA == '0 && PSTRB == '0));

endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin grant: the requester after the last granted one wins; the pointer
// resets to the top requester so requester 0 has priority out of reset.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_onehot
);

  logic [NUM_REQ-1:0] last_q;
  logic [NUM_REQ-1:0] last_d;
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] masked_req;

  // Bits strictly above the one-hot pointer; empty when the pointer is the top bit.
  assign upper_mask = ~((last_q << 1) - NUM_REQ'(1));
  assign masked_req = req & upper_mask;

  always_comb begin
    grant_onehot = '0;
    if (|masked_req) begin
      grant_onehot = masked_req & (~masked_req + NUM_REQ'(1));
    end else begin
      grant_onehot = req & (~req + NUM_REQ'(1));
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && (|grant_onehot)) begin
      last_d = grant_onehot;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      last_q <= NUM_REQ'(1) << (NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB slave among NUM_REQ requesters with round-robin grants.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles.
module apb_arbiter
  import apb_package::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]  req_strb,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  apb_interface.master               apb
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("apb_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  apb_arb_state_e     state_q;
  apb_arb_state_e     state_d;
  logic               advance;
  logic               complete;
  logic               tmo_hit;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] grant_q;
  apb_req_t           fld_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .req          (req_valid),
    .advance      (advance),
    .grant_onehot (grant_onehot)
  );

  // One-hot AND-OR select of the granted requester's fields.
  apb_req_t fld_chain [NUM_REQ+1];
  assign fld_chain[0] = '0;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
    apb_req_t fld;
    assign fld.write = req_write[gi];
    assign fld.addr  = req_addr[gi*ADDR_W +: ADDR_W];
    assign fld.wdata = req_write[gi] ? req_wdata[gi*DATA_W +: DATA_W] : '0;
    assign fld.strb  = req_write[gi] ? req_strb[gi*STRB_W +: STRB_W] : '0;
    assign fld_chain[gi+1] = apb_req_t'(fld_chain[gi] | (grant_onehot[gi] ? fld : '0));
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Counter holds the number of earlier waited ACCESS cycles; the last one aborts.
  assign tmo_hit = (state_q == ACCESS) && !apb.PREADY && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge PCLK) begin
    if (!PRESETn || state_q != ACCESS) begin
      tmo_cnt_q <= '0;
    end else if (!apb.PREADY) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    advance  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          advance = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb.PREADY) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      fld_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      if (advance) begin
        grant_q <= grant_onehot;
        fld_q   <= fld_chain[NUM_REQ];
      end
      if (complete) begin
        rsp_valid_q <= grant_q;
        rsp_rdata_q <= fld_q.write ? '0 : apb.PRDATA;
        rsp_err_q   <= apb.PSLVERR;
      end else if (tmo_hit) begin
        rsp_valid_q <= grant_q;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  // The grant pulse is combinational, so it is masked while reset is asserted.
  assign req_ready   = {NUM_REQ{advance & PRESETn}} & grant_onehot;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

  assign apb.PSELx   = (state_q != IDLE);
  assign apb.PENABLE = (state_q == ACCESS);
  assign apb.PWRITE  = (state_q != IDLE) && fld_q.write;
  assign apb.PADDR   = (state_q != IDLE) ? fld_q.addr  : '0;
  assign apb.PWDATA  = (state_q != IDLE) ? fld_q.wdata : '0;
  assign apb.PSTRB   = (state_q != IDLE) ? fld_q.strb  : '0;

endmodule
